// File: rtl/immediate_generator_pipe.sv
// Pipelined RISC-V immediate generator: extracts and extends immediates to XLEN bits and
// carries them, with an invalid flag and a sideband tag, through a valid/ready register pipeline.
module immediate_generator_pipe #(
    parameter int XLEN      = 32,
    parameter int STAGES    = 1,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:7]          instruction,
    input  logic [2:0]           instruction_type,
    input  logic [1:0]           imm_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      immediate,
    output logic                 imm_invalid,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam logic [2:0] I_TYPE = 3'b001;
    localparam logic [2:0] S_TYPE = 3'b010;
    localparam logic [2:0] B_TYPE = 3'b011;
    localparam logic [2:0] U_TYPE = 3'b100;
    localparam logic [2:0] J_TYPE = 3'b101;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_ZIMM   = 2'd1;
    localparam logic [1:0] MODE_SHAMT  = 2'd2;

    // Returns {invalid, immediate}; undefined type/mode combinations yield a zero immediate.
    function automatic logic [XLEN:0] extract(
        input logic [31:7] inst,
        input logic [2:0]  ty,
        input logic [1:0]  md
    );
        logic signed [XLEN-1:0] imm;
        logic                   inv;
        imm = '0;
        inv = 1'b0;
        case (md)
            MODE_NORMAL: begin
                case (ty)
                    I_TYPE:  imm = XLEN'($signed(inst[31:20]));
                    S_TYPE:  imm = XLEN'($signed({inst[31:25], inst[11:7]}));
                    B_TYPE:  imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
                    U_TYPE:  imm = XLEN'($signed({inst[31:12], 12'b0}));
                    J_TYPE:  imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
                    default: inv = 1'b1;
                endcase
            end
            MODE_ZIMM:  imm = XLEN'(inst[19:15]);
            MODE_SHAMT: imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            default:    inv = 1'b1;
        endcase
        return {inv, imm};
    endfunction

    // Stage 0: combinational extraction at the pipeline input
    logic [XLEN-1:0] imm_p0;
    logic            inv_p0;

    assign {inv_p0, imm_p0} = extract(instruction, instruction_type, imm_mode);

    // Stage 1
    logic                 vld_p1;
    logic [XLEN-1:0]      imm_p1;
    logic                 inv_p1;
    logic [TAG_WIDTH-1:0] tag_p1;
    logic                 next_ready_p1;
    logic                 load_p1;

    assign load_p1  = !vld_p1 || next_ready_p1;
    assign in_ready = load_p1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            imm_p1 <= '0;
            inv_p1 <= 1'b0;
            tag_p1 <= '0;
        end else if (load_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                imm_p1 <= imm_p0;
                inv_p1 <= inv_p0;
                tag_p1 <= in_tag;
            end
        end
    end

    // Stage 2 (optional): re-registers stage 1 unchanged
    if (STAGES == 2) begin : g_stage2
        logic                 vld_p2;
        logic [XLEN-1:0]      imm_p2;
        logic                 inv_p2;
        logic [TAG_WIDTH-1:0] tag_p2;
        logic                 load_p2;

        assign load_p2       = !vld_p2 || out_ready;
        assign next_ready_p1 = load_p2;

        always_ff @(posedge clk) begin
            if (!reset) begin
                vld_p2 <= 1'b0;
                imm_p2 <= '0;
                inv_p2 <= 1'b0;
                tag_p2 <= '0;
            end else if (load_p2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    imm_p2 <= imm_p1;
                    inv_p2 <= inv_p1;
                    tag_p2 <= tag_p1;
                end
            end
        end

        assign out_valid   = vld_p2;
        assign immediate   = imm_p2;
        assign imm_invalid = inv_p2;
        assign out_tag     = tag_p2;
    end else begin : g_stage1_out
        assign next_ready_p1 = out_ready;
        assign out_valid     = vld_p1;
        assign immediate     = imm_p1;
        assign imm_invalid   = inv_p1;
        assign out_tag       = tag_p1;
    end

endmodule

// File: doc/immediate_generator_pipe.md
# immediate_generator_pipe

Parametrised, pipelined successor to the combinational immediate generator. It extracts and sign- or zero-extends RISC-V immediates to XLEN bits, and adds CSR-zimm and shift-amount modes. It carries a sideband tag, flags undefined types, and moves data through a valid/ready elastic pipeline of STAGES registers. It sits between the decode and register-read/execute stages of the phoeniX pipeline.

## Interface
- XLEN, 32, output width; legal values 32 or 64.
- STAGES, 1, number of register stages; legal values 1 or 2.
- TAG_WIDTH, 5, width of the opaque sideband carried with each item (e.g. rd index).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- in_valid  input  1  upstream item valid.
- in_ready  output  1  block can accept an item this cycle.
- instruction  input  [31:7]  instruction bits, opcode excluded.
- instruction_type  input  3  type code using the Defines.v encodings I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE.
- imm_mode  input  2  0 = normal, 1 = CSR zimm, 2 = shift amount, 3 = reserved.
- in_tag  input  TAG_WIDTH  sideband, passed through unchanged.
- out_valid  output  1  output item valid.
- out_ready  input  1  downstream accepts the output this cycle.
- immediate  output  XLEN  extended immediate.
- imm_invalid  output  1  set for undefined type/mode combinations.
- out_tag  output  TAG_WIDTH  sideband matching `immediate`.

## Operation
- Mode 0 extraction:
  - I: sign-extend inst[31:20].
  - S: sign-extend {inst[31:25], inst[11:7]}.
  - B: sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - J: sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Mode 1: zero-extend inst[19:15]. instruction_type is ignored.
- Mode 2:
  - XLEN=32: zero-extend inst[24:20].
  - XLEN=64: zero-extend inst[25:20].
  - instruction_type is ignored.
- Invalid cases: mode 3, or mode 0 with a type code outside {I, S, B, U, J}. For these, immediate = 0 and imm_invalid = 1. The item still flows through the pipeline; it is never dropped. No output is ever driven to Z.
- Extraction is combinational at the stage-1 input. Stage 1 registers {immediate, imm_invalid, tag}. When STAGES=2, stage 2 re-registers the same fields unchanged.
- Per-stage rule:
  - Stage k loads when it is empty or its contents advance this cycle.
  - A stage advances when it is valid and the next stage (or out_ready, for the last stage) accepts.
- in_ready = stage 1 empty OR stage 1 advancing. This is a combinational path from out_ready.
- Ordering is strictly FIFO. Items are never duplicated or reordered.

## Timing
- Reset (reset = 0 at a rising edge):
  - All stage valids, out_valid, immediate, imm_invalid and out_tag clear to 0.
  - in_ready is 1 from the first cycle after reset.
  - Reset asserted mid-stream discards all in-flight items.
- Latency: an item accepted in cycle N (in_valid & in_ready) appears with out_valid = 1 in cycle N+STAGES, provided the pipeline is not stalled.
- Throughput: 1 item per cycle while out_ready = 1.
- Stall: when out_valid = 1 and out_ready = 0, immediate, imm_invalid and out_tag hold stable.
  - STAGES=1: in_ready = 0.
  - STAGES=2: one more item may enter, then in_ready = 0.
- Simultaneous accept and drain on a full stage: the stage replaces its contents in the same cycle, with no bubble.
- in_valid = 0: no stage loads; existing items still drain.
- Inputs are ignored while in_valid = 0 and while in_ready = 0 (no accept).

## Test plan
- Reset, XLEN=32, STAGES=1: hold reset = 0 for 2 cycles, then release -> out_valid = 0, immediate = 0, in_ready = 1.
- I/B streaming, STAGES=2, out_ready = 1:
  - Stimulus: back-to-back 0xFFF00093 (I-type), 0xFE000EE3 (B-type), tags 1 and 2.
  - Required: 0xFFFFFFFF with tag 1 at cycle N+2, then 0xFFFFFFFC with tag 2 at cycle N+3.
- U-type with XLEN=64: 0x800000B7, U_TYPE, mode 0 -> 0xFFFFFFFF80000000.
- Special modes, XLEN=64:
  - Mode 1 with inst[19:15] = 5'b11111 -> 0x1F.
  - Mode 2 with inst[25:20] = 6'b111111 -> 0x3F.
  - Mode 3 -> immediate 0, imm_invalid 1.
- Backpressure, STAGES=2:
  - Stimulus: out_ready = 0 for 4 cycles while in_valid = 1 with 3 distinct items.
  - Required: exactly 2 items accepted; in_ready = 0 afterwards; outputs stable; items drain in order once out_ready = 1.
- Reset mid-stream: assert reset with 2 items in flight -> the next cycle shows out_valid = 0, and no stale item appears after release.
